// File: rtl/srl_fifo_storage.sv
// Shift-register storage for the SRL FIFO: new words enter entry 0 on shift,
// the oldest word is read combinationally by address. Contents are never reset.
module srl_fifo_storage #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (shift_en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Addresses past DEPTH only occur when the FIFO is empty and are never loaded.
    always_comb begin
        dout = '0;
        if (int'(addr) < DEPTH) begin
            dout = mem_q[addr];
        end
    end

endmodule

// File: rtl/srl_fifo_read_ctrl.sv
// SRL FIFO with a registered first-word-fall-through output stage.
// Capacity is DEPTH words in the shift register plus one in the output register.
module srl_fifo_read_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic                  push, pop, load;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] srl_dout;

    assign push    = if_write_ce & if_write & full_n_q;
    assign pop     = if_read_ce & if_read & empty_n_q;
    assign load    = (cnt_q != '0) & (~empty_n_q | pop);
    assign rd_addr = ADDR_WIDTH'(cnt_q - CW'(1));

    srl_fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk      (clk),
        .shift_en (push),
        .din      (if_din),
        .addr     (rd_addr),
        .dout     (srl_dout)
    );

    always_comb begin
        cnt_d = cnt_q;
        case ({push, load})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        full_n_d = (cnt_d < DEPTH_C);
    end

    // The read address sees the pre-shift storage, so a concurrent push never disturbs the load.
    always_comb begin
        empty_n_d = empty_n_q;
        dout_d    = dout_q;
        if (load) begin
            empty_n_d = 1'b1;
            dout_d    = srl_dout;
        end else if (pop) begin
            empty_n_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
            dout_q    <= dout_d;
        end
    end

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign if_dout    = dout_q;

endmodule

// File: doc/srl_fifo_read_ctrl.md
SRL_FIFO_READ_CTRL -- requirements
Module: srl_fifo_read_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1: payload width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 1: shift-register address width; 2**ADDR_WIDTH >= DEPTH.
REQ-003 SHALL have parameter DEPTH, default 2: shift-register storage entries.
REQ-004 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port if_full_n  output  1: high = write side can accept a word.
REQ-007 SHALL have port if_write_ce  input  1: write-side clock enable.
REQ-008 SHALL have port if_write  input  1: write request.
REQ-009 SHALL have port if_din  input  DATA_WIDTH: write data.
REQ-010 SHALL have port if_empty_n  output  1: high = if_dout holds a valid word.
REQ-011 SHALL have port if_read_ce  input  1: read-side clock enable.
REQ-012 SHALL have port if_read  input  1: read request, consumes if_dout.
REQ-013 SHALL have port if_dout  output  DATA_WIDTH: registered read data, first-word-fall-through.

Function
REQ-014 SHALL define push = if_write_ce & if_write & if_full_n; writes with if_full_n low are ignored and SHALL NOT alter state.
REQ-015 SHALL define pop = if_read_ce & if_read & if_empty_n; reads with if_empty_n low are ignored.
REQ-016 SHALL track SRL occupancy cnt in 0..DEPTH; on push the storage shifts and if_din enters entry 0.
REQ-017 SHALL drive storage read address = cnt-1 (oldest entry); address value when cnt==0 is don't-care and SHALL NOT be loaded.
REQ-018 SHALL perform load = (cnt>0) & (!if_empty_n | pop): if_dout <= storage[cnt-1] (pre-shift value), if_empty_n <= 1.
REQ-019 SHALL clear if_empty_n on pop when no load occurs in the same cycle.
REQ-020 SHALL update cnt: +1 on push only, -1 on load only, unchanged on push & load together.
REQ-021 SHALL drive if_full_n = (cnt < DEPTH), registered; total capacity = DEPTH+1 words (SRL plus output register).
REQ-022 SHALL provide write-to-if_empty_n latency of 2 cycles when empty (no bypass); sustained throughput 1 word/cycle once primed.
REQ-023 SHALL preserve strict FIFO order under all push/pop interleavings.
REQ-024 SHALL hold if_dout stable while if_empty_n is high and no pop occurs.
REQ-025 When full (cnt==DEPTH, output valid), pop SHALL load the next word and raise if_full_n the following cycle.
REQ-026 With cnt==0 and output valid, simultaneous push & pop SHALL drop if_empty_n for one cycle, then present the pushed word.

Reset
REQ-027 reset SHALL force cnt=0, if_empty_n=0, if_full_n=1, if_dout=0 on the next rising edge, overriding any concurrent push/pop.
REQ-028 Storage contents SHALL NOT be reset; reset mid-operation discards all buffered words.

Structure
REQ-029 Storage SHALL be a single sub-module srl_fifo_storage (shift-on-write array, combinational read by address, no reset); control in the top.
REQ-030 No shared package; occupancy width derived locally as ADDR_WIDTH+1 bits.

Verification (DATA_WIDTH=8, DEPTH=2, ADDR_WIDTH=1, CE tied high unless stated)
REQ-031 Reset then idle -> if_full_n=1, if_empty_n=0, if_dout=0x00.
REQ-032 Push 0xA1 at cycle 0, no reads -> if_empty_n=1 with if_dout=0xA1 at cycle 2.
REQ-033 Push 0x11,0x22,0x33,0x44 back-to-back, no reads -> accepts three, if_full_n=0 after third; 0x44 ignored; reads return 0x11,0x22,0x33, then if_empty_n=0.
REQ-034 Continuous push 0x01..0x10 with continuous read -> output 0x01..0x10 in order, one per cycle after 2-cycle prime.
REQ-035 Full FIFO, assert reset with push and pop high -> next cycle cnt=0, if_empty_n=0, if_full_n=1; subsequent push 0x5A read back as 0x5A.
REQ-036 if_read_ce=0 with if_read=1 and valid data -> if_dout held, no word lost.
